call_stack: RTL and testbench

Return-address stack and branch-request arbiter for the 8-bit core. It sits directly upstream of the program counter and drives that block's load-enable and load-address inputs. It resolves jump, call and return requests from the decoder into a single PC load, and it keeps a bounded LIFO of return addresses with fault flags for overflow and underflow.

---
 rtl/call_stack.sv | 122 ++++++++++++
 tb/tb_call_stack.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/call_stack.sv
// Return-address stack and branch-request arbiter feeding the program counter load port.
// Resolves ret > call > jump into one PC load and keeps a bounded LIFO with sticky fault flags.
module call_stack #(
  parameter int PC_WIDTH    = 8,
  parameter int STACK_DEPTH = 4,
  parameter int CNT_WIDTH   = $clog2(STACK_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 res_n,
  input  logic [PC_WIDTH-1:0]  pc,
  input  logic                 jump,
  input  logic                 call,
  input  logic                 ret,
  input  logic [PC_WIDTH-1:0]  target,
  input  logic                 clr_err,
  output logic                 wr_en,
  output logic [PC_WIDTH-1:0]  counteradress,
  output logic [CNT_WIDTH-1:0] sp,
  output logic                 empty,
  output logic                 full,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int                   IDX_WIDTH = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [CNT_WIDTH-1:0] DEPTH_C   = CNT_WIDTH'(STACK_DEPTH);
  localparam logic [CNT_WIDTH-1:0] ONE_C     = CNT_WIDTH'(1);
  localparam logic [PC_WIDTH-1:0]  PC_ONE_C  = PC_WIDTH'(1);

  function automatic logic [PC_WIDTH-1:0] f_ret_addr(input logic [PC_WIDTH-1:0] a);
    return a + PC_ONE_C;
  endfunction

  logic [PC_WIDTH-1:0]  r_mem [STACK_DEPTH];
  logic [CNT_WIDTH-1:0] r_sp;
  logic                 r_ovf;
  logic                 r_unf;

  logic                 w_empty;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_jump;
  logic                 w_ovf_evt;
  logic                 w_unf_evt;
  logic [IDX_WIDTH-1:0] w_top_idx;
  logic [IDX_WIDTH-1:0] w_push_idx;
  logic [PC_WIDTH-1:0]  w_top;

  assign w_empty    = (r_sp == {CNT_WIDTH{1'b0}});
  assign w_full     = (r_sp == DEPTH_C);
  assign w_pop      = ret & ~w_empty;
  assign w_unf_evt  = ret & w_empty;
  assign w_push     = ~ret & call & ~w_full;
  assign w_ovf_evt  = ~ret & call & w_full;
  assign w_jump     = ~ret & ~call & jump;
  // Index truncation is safe: the pop index is only used when sp >= 1, the push index when sp < depth.
  assign w_top_idx  = IDX_WIDTH'(r_sp - ONE_C);
  assign w_push_idx = IDX_WIDTH'(r_sp);
  assign w_top      = r_mem[w_top_idx];

  // PC load request: zero-latency selection of the winning request.
  always_comb begin
    wr_en         = 1'b0;
    counteradress = {PC_WIDTH{1'b0}};
    if (w_pop) begin
      wr_en         = 1'b1;
      counteradress = w_top;
    end else if (w_push) begin
      wr_en         = 1'b1;
      counteradress = target;
    end else if (w_jump) begin
      wr_en         = 1'b1;
      counteradress = target;
    end else begin
      wr_en         = 1'b0;
      counteradress = {PC_WIDTH{1'b0}};
    end
  end

  // Return-address storage; popped entries keep their value.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        r_mem[i] <= {PC_WIDTH{1'b0}};
      end
    end else if (w_push) begin
      r_mem[w_push_idx] <= f_ret_addr(pc);
    end
  end

  // Occupancy count.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_sp <= {CNT_WIDTH{1'b0}};
    end else if (w_push) begin
      r_sp <= r_sp + ONE_C;
    end else if (w_pop) begin
      r_sp <= r_sp - ONE_C;
    end else begin
      r_sp <= r_sp;
    end
  end

  // Sticky fault flags; a fresh fault beats a simultaneous clear.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= w_ovf_evt ? 1'b1 : (clr_err ? 1'b0 : r_ovf);
      r_unf <= w_unf_evt ? 1'b1 : (clr_err ? 1'b0 : r_unf);
    end
  end

  assign sp        = r_sp;
  assign empty     = w_empty;
  assign full      = w_full;
  assign overflow  = r_ovf;
  assign underflow = r_unf;

endmodule

// File: tb/tb_call_stack.sv
// Self-checking bench for call_stack: directed vector table, a mid-sequence reset,
// then randomized requests checked against a queue-based reference model.
module tb_call_stack;

  localparam int DEPTH = 4;

  logic       clk;
  logic       res_n;
  logic [7:0] pc;
  logic       jump;
  logic       call;
  logic       ret;
  logic [7:0] target;
  logic       clr_err;
  logic       wr_en;
  logic [7:0] counteradress;
  logic [2:0] sp;
  logic       empty;
  logic       full;
  logic       overflow;
  logic       underflow;

  call_stack #(.PC_WIDTH(8), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .res_n(res_n), .pc(pc), .jump(jump), .call(call), .ret(ret),
    .target(target), .clr_err(clr_err), .wr_en(wr_en), .counteradress(counteradress),
    .sp(sp), .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       j;
    logic       c;
    logic       r;
    logic       clr;
    logic [7:0] pc;
    logic [7:0] tgt;
    logic       wr;
    logic [7:0] addr;
    int         sp;
    logic       ovf;
    logic       unf;
  } vec_t;

  vec_t       tbl[$];
  int         checks;
  int         failures;

  logic [7:0] m_stk[$];
  logic       m_ovf;
  logic       m_unf;

  function automatic vec_t mk(logic j, logic c, logic r, logic clr, logic [7:0] p, logic [7:0] t,
                              logic w, logic [7:0] a, int s, logic o, logic u);
    vec_t v;
    v.j = j; v.c = c; v.r = r; v.clr = clr; v.pc = p; v.tgt = t;
    v.wr = w; v.addr = a; v.sp = s; v.ovf = o; v.unf = u;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: the specification's rules expressed over a queue.
  task automatic model_apply(input logic j, input logic c, input logic r, input logic clr,
                             input logic [7:0] p, input logic [7:0] t,
                             output logic w, output logic [7:0] a);
    logic       oe;
    logic       ue;
    logic [7:0] ra;
    w = 1'b0; a = 8'h00; oe = 1'b0; ue = 1'b0;
    if (r) begin
      if (m_stk.size() > 0) begin w = 1'b1; a = m_stk.pop_back(); end
      else ue = 1'b1;
    end else if (c) begin
      if (m_stk.size() < DEPTH) begin
        w = 1'b1; a = t; ra = p + 8'd1; m_stk.push_back(ra);
      end else oe = 1'b1;
    end else if (j) begin
      w = 1'b1; a = t;
    end
    m_ovf = oe ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_unf = ue ? 1'b1 : (clr ? 1'b0 : m_unf);
  endtask

  task automatic step(input vec_t v, input bit from_table);
    logic       mw;
    logic [7:0] ma;
    logic       ew;
    logic [7:0] ea;
    int         es;
    logic       eo;
    logic       eu;
    @(negedge clk);
    jump = v.j; call = v.c; ret = v.r; clr_err = v.clr; pc = v.pc; target = v.tgt;
    model_apply(v.j, v.c, v.r, v.clr, v.pc, v.tgt, mw, ma);
    ew = from_table ? v.wr   : mw;
    ea = from_table ? v.addr : ma;
    es = from_table ? v.sp   : m_stk.size();
    eo = from_table ? v.ovf  : m_ovf;
    eu = from_table ? v.unf  : m_unf;
    #1;
    chk("wr_en", 32'(wr_en), 32'(ew));
    chk("counteradress", 32'(counteradress), 32'(ea));
    @(posedge clk);
    #1;
    chk("sp", 32'(sp), 32'(es));
    chk("empty", 32'(empty), 32'(es == 0));
    chk("full", 32'(full), 32'(es == DEPTH));
    chk("overflow", 32'(overflow), 32'(eo));
    chk("underflow", 32'(underflow), 32'(eu));
  endtask

  initial begin
    checks = 0; failures = 0;
    m_ovf = 1'b0; m_unf = 1'b0;
    jump = 1'b0; call = 1'b0; ret = 1'b0; clr_err = 1'b0; pc = 8'h00; target = 8'h00;

    //            j    c    r    clr  pc      tgt     wr   addr    sp ovf  unf
    tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,8'h00,8'h00,1'b0,8'h00,0,1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,8'h05,8'h20,1'b1,8'h20,1,1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b0,1'b1,1'b0,8'h00,8'h00,1'b1,8'h06,0,1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,8'd10,8'h50,1'b1,8'h50,1,1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,8'd20,8'h51,1'b1,8'h51,2,1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,8'd30,8'h52,1'b1,8'h52,3,1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,8'd40,8'h53,1'b1,8'h53,4,1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,8'h99,8'h80,1'b0,8'h00,4,1'b1,1'b0));
    tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1,8'h00,8'h00,1'b0,8'h00,4,1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b0,1'b1,1'b0,8'h00,8'h00,1'b1,8'd41,3,1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b0,1'b1,1'b0,8'h00,8'h00,1'b1,8'd31,2,1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b0,1'b1,1'b0,8'h00,8'h00,1'b1,8'd21,1,1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b0,1'b1,1'b0,8'h00,8'h00,1'b1,8'd11,0,1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b0,1'b1,1'b0,8'h00,8'h00,1'b0,8'h00,0,1'b0,1'b1));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,8'h00,8'h00,1'b0,8'h00,0,1'b0,1'b1));
    tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1,8'h00,8'h00,1'b0,8'h00,0,1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,8'h32,8'h10,1'b1,8'h10,1,1'b0,1'b0));
    tbl.push_back(mk(1'b1,1'b1,1'b1,1'b0,8'h77,8'h99,1'b1,8'h33,0,1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,8'hFF,8'h12,1'b1,8'h12,1,1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b0,1'b1,1'b0,8'h00,8'h00,1'b1,8'h00,0,1'b0,1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,1'b0,8'h00,8'hAB,1'b1,8'hAB,0,1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,8'h01,8'h61,1'b1,8'h61,1,1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,8'h02,8'h62,1'b1,8'h62,2,1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,8'h03,8'h63,1'b1,8'h63,3,1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,8'h04,8'h64,1'b1,8'h64,4,1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b1,8'h05,8'h70,1'b0,8'h00,4,1'b1,1'b0));
    tbl.push_back(mk(1'b0,1'b0,1'b1,1'b1,8'h00,8'h00,1'b1,8'h05,3,1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b0,1'b1,1'b0,8'h00,8'h00,1'b1,8'h04,2,1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b0,1'b1,1'b0,8'h00,8'h00,1'b1,8'h03,1,1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b0,1'b1,1'b0,8'h00,8'h00,1'b1,8'h02,0,1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b0,1'b1,1'b1,8'h00,8'h00,1'b0,8'h00,0,1'b0,1'b1));
    tbl.push_back(mk(1'b1,1'b1,1'b0,1'b0,8'h40,8'h60,1'b1,8'h60,1,1'b0,1'b1));
    tbl.push_back(mk(1'b1,1'b0,1'b0,1'b0,8'h00,8'h7E,1'b1,8'h7E,1,1'b0,1'b1));
    tbl.push_back(mk(1'b1,1'b0,1'b0,1'b1,8'h00,8'h01,1'b1,8'h01,1,1'b0,1'b0));

    res_n = 1'b0;
    #10;
    res_n = 1'b1;
    #1;
    chk("rst_sp", 32'(sp), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_addr", 32'(counteradress), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_underflow", 32'(underflow), 32'd0);

    foreach (tbl[i]) step(tbl[i], 1'b1);

    // Reset asserted mid-sequence, with a call in flight.
    @(negedge clk);
    call = 1'b1; pc = 8'h10; target = 8'h20;
    #2;
    res_n = 1'b0;
    #1;
    chk("midrst_sp", 32'(sp), 32'd0);
    chk("midrst_empty", 32'(empty), 32'd1);
    chk("midrst_overflow", 32'(overflow), 32'd0);
    call = 1'b0;
    @(negedge clk);
    res_n = 1'b1;
    m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    step(mk(1'b0,1'b0,1'b1,1'b0,8'h00,8'h00,1'b0,8'h00,0,1'b0,1'b1), 1'b1);
    step(mk(1'b0,1'b0,1'b0,1'b1,8'h00,8'h00,1'b0,8'h00,0,1'b0,1'b0), 1'b1);

    for (int n = 0; n < 400; n++) begin
      vec_t v;
      v = mk(($urandom % 4) == 0, ($urandom % 3) == 0, ($urandom % 3) == 0,
             ($urandom % 8) == 0, 8'($urandom), 8'($urandom),
             1'b0, 8'h00, 0, 1'b0, 1'b0);
      step(v, 1'b0);
    end

    @(negedge clk);
    jump = 1'b0; call = 1'b0; ret = 1'b0; clr_err = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
